// File: rtl/data_ram_if.sv
// data_ram_if: request/response bus between a load/store requester and a data RAM responder.
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address (bits [1:0] ignored)
//   req_wdata/req_wmask : store word and byte-lane enables
//   rsp_valid           : one-cycle response strobe
//   rsp_rdata/rsp_error : load word and out-of-window flag, valid with rsp_valid
interface data_ram_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_ram_responder.sv
// data_ram_responder: word-addressed data RAM with byte-lane stores, configurable wait states and window check.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset (RAM contents are kept)
//   bus   : data_ram_if.slave request/response port
module data_ram_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input logic       clk,
    input logic       reset,
    data_ram_if.slave bus
);
    localparam logic [31:0] WIN_MASK = ~((32'd4 << ADDR_WIDTH) - 32'd1);
    localparam logic [3:0]  LAT_M1   = LATENCY > 0 ? 4'(LATENCY - 1) : 4'd0;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t                  state, state_n;
    logic [3:0]              cnt, cnt_n;
    logic [31:0]             mem [2**ADDR_WIDTH];
    logic                    we_q, hit_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wmask_q;
    logic                    take, hit_in, rd_we, rd_hit;
    logic [ADDR_WIDTH-1:0]   rd_idx;
    assign take          = state == IDLE && bus.req_valid;
    assign hit_in        = (bus.req_addr & WIN_MASK) == BASE_ADDR;
    // With zero latency RESP is entered straight from the handshake, so the
    // registered read must use the live request rather than the captured one.
    assign rd_we         = take ? bus.req_we : we_q;
    assign rd_hit        = take ? hit_in : hit_q;
    assign rd_idx        = take ? bus.req_addr[ADDR_WIDTH+1:2] : idx_q;
    assign bus.req_ready = state == IDLE;
    assign bus.rsp_valid = state == RESP;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (bus.req_valid) begin
                state_n = LATENCY > 0 ? WAIT : RESP;
                cnt_n   = LAT_M1;
            end
            WAIT: begin
                state_n = cnt == 4'd0 ? RESP : WAIT;
                cnt_n   = cnt == 4'd0 ? cnt : cnt - 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_error <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            bus.rsp_rdata <= (state_n == RESP && !rd_we && rd_hit) ? mem[rd_idx] : 32'd0;
            bus.rsp_error <= state_n == RESP && !rd_hit;
            if (take) begin
                we_q    <= bus.req_we;
                hit_q   <= hit_in;
                idx_q   <= bus.req_addr[ADDR_WIDTH+1:2];
                wdata_q <= bus.req_wdata;
                wmask_q <= bus.req_wmask;
            end
        end
    end
    // Stores commit on the edge that ends RESP; a reset on that edge drops them.
    always_ff @(posedge clk) begin
        if (!reset && state == RESP && we_q && hit_q)
            for (int i = 0; i < 4; i++)
                if (wmask_q[i]) mem[idx_q][8*i+:8] <= wdata_q[8*i+:8];
    end
endmodule

// File: tb/tb_data_ram_responder.sv
// tb_data_ram_responder: self-checking bench for data_ram_responder at LATENCY 0, 1 and 3.
module tb_data_ram_responder;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;

    data_ram_if b0 ();
    data_ram_if b1 ();
    data_ram_if b3 ();
    data_ram_responder #(.LATENCY(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
    data_ram_responder #(.LATENCY(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
    data_ram_responder #(.LATENCY(3)) u3 (.clk(clk), .reset(reset), .bus(b3));

    virtual data_ram_if vif;
    int lat;
    logic [31:0] ref_mem [int];

    // Reference: 4 KiB window at address 0; words keyed per DUT instance.
    function automatic void ref_op(input int l, input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] mask,
                                   output logic [31:0] rd, output logic er);
        int key = l * 1024 + int'(addr[11:2]);
        rd = 32'd0;
        er = !(addr < 32'h1000);
        if (!er && we) begin
            for (int i = 0; i < 4; i++)
                if (mask[i]) ref_mem[key][8*i+:8] = wdata[8*i+:8];
        end else if (!er) begin
            rd = ref_mem.exists(key) ? ref_mem[key] : 32'd0;
        end
    endfunction

    task automatic use_dut(input int l);
        lat = l;
        case (l)
            0:       vif = b0;
            1:       vif = b1;
            default: vif = b3;
        endcase
    endtask

    // One request; n = number of falling edges after the handshake edge until rsp_valid is seen.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, output logic [31:0] rd, output logic er,
                        output int n);
        int g = 0;
        @(negedge clk);
        vif.req_valid = 1'b1;
        vif.req_we    = we;
        vif.req_addr  = addr;
        vif.req_wdata = wdata;
        vif.req_wmask = mask;
        while (!vif.req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (vif.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout lat=%0d got req_ready=%b want 1", lat, vif.req_ready);
        end
        @(posedge clk);
        #1;
        vif.req_valid = 1'b0;
        vif.req_we    = 1'($urandom);
        vif.req_addr  = $urandom;
        vif.req_wdata = $urandom;
        vif.req_wmask = 4'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vif.rsp_valid && n < 40);
        rd = vif.rsp_rdata;
        er = vif.rsp_error;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            use_dut(k == 2 ? 3 : k);
            checks++;
            if ({vif.req_ready, vif.rsp_valid, vif.rsp_error, vif.rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
                errors++;
                $display("FAIL reset lat=%0d got ready=%b valid=%b err=%b rdata=%h want 1 0 0 0",
                         lat, vif.req_ready, vif.rsp_valid, vif.rsp_error, vif.rsp_rdata);
            end
        end
    endtask

    task automatic test_store_load;
        logic [31:0] rd;
        logic er;
        int n;
        use_dut(1);
        xact(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, rd, er, n);
        checks++;
        if (n != 2 || rd !== 32'd0 || er !== 1'b0) begin
            errors++;
            $display("FAIL store_0x40 got n=%0d rdata=%h err=%b want n=2 rdata=0 err=0", n, rd, er);
        end
        xact(1'b0, 32'h40, 32'h0, 4'h0, rd, er, n);
        checks++;
        if (n != 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL load_0x40 got n=%0d rdata=%h err=%b want n=2 rdata=deadbeef err=0", n, rd, er);
        end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] rd;
        logic er;
        int n;
        use_dut(1);
        xact(1'b1, 32'h42, 32'h00AA0000, 4'b0100, rd, er, n);
        xact(1'b0, 32'h40, 32'h0, 4'h0, rd, er, n);
        checks++;
        if (rd !== 32'hDEAABEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL byte_lane got rdata=%h err=%b want deaabeef 0", rd, er);
        end
        xact(1'b1, 32'h40, 32'h12340000, 4'b1100, rd, er, n);
        xact(1'b0, 32'h40, 32'h0, 4'h0, rd, er, n);
        checks++;
        if (rd !== 32'h1234BEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL half_lane got rdata=%h err=%b want 1234beef 0", rd, er);
        end
        xact(1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, rd, er, n);
        xact(1'b0, 32'h40, 32'h0, 4'h0, rd, er, n);
        checks++;
        if (rd !== 32'h1234BEEF || n != 2) begin
            errors++;
            $display("FAIL zero_mask got rdata=%h n=%0d want 1234beef n=2", rd, n);
        end
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd;
        logic er;
        int n;
        use_dut(1);
        xact(1'b1, 32'h0, 32'h5A5A1234, 4'hF, rd, er, n);
        xact(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, er, n);
        checks++;
        if (rd !== 32'd0 || er !== 1'b1 || n != 2) begin
            errors++;
            $display("FAIL oor_store got rdata=%h err=%b n=%0d want 0 1 2", rd, er, n);
        end
        xact(1'b0, 32'hFFFF_F000, 32'h0, 4'h0, rd, er, n);
        checks++;
        if (rd !== 32'd0 || er !== 1'b1) begin
            errors++;
            $display("FAIL oor_load got rdata=%h err=%b want 0 1", rd, er);
        end
        xact(1'b0, 32'h0, 32'h0, 4'h0, rd, er, n);
        checks++;
        if (rd !== 32'h5A5A1234 || er !== 1'b0) begin
            errors++;
            $display("FAIL oor_readback got rdata=%h err=%b want 5a5a1234 0", rd, er);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, erd, addr, wd;
        logic er, eer, we;
        logic [3:0] mask;
        int n;
        for (int li = 0; li < 3; li++) begin
            use_dut(li == 2 ? 3 : li);
            for (int w = 0; w < 16; w++) begin
                addr = 32'h40 + 32'(4 * w);
                wd   = $urandom;
                ref_op(lat, 1'b1, addr, wd, 4'hF, erd, eer);
                xact(1'b1, addr, wd, 4'hF, rd, er, n);
            end
            for (int k = 0; k < 25; k++) begin
                we   = 1'($urandom);
                mask = 4'($urandom);
                wd   = $urandom;
                addr = ($urandom_range(0, 5) == 0) ? ($urandom | 32'h1000)
                                                   : 32'h40 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
                ref_op(lat, we, addr, wd, mask, erd, eer);
                xact(we, addr, wd, mask, rd, er, n);
                checks++;
                if (rd !== erd || er !== eer || n != lat + 1) begin
                    errors++;
                    $display("FAIL random lat=%0d we=%b addr=%h got rdata=%h err=%b n=%0d want %h %b %0d",
                             lat, we, addr, rd, er, n, erd, eer, lat + 1);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] erd, rd;
        logic eer, er;
        int n;
        use_dut(0);
        @(negedge clk);
        b0.req_valid = 1'b1;
        b0.req_we    = 1'b0;
        b0.req_addr  = 32'h40;
        for (int i = 0; i < 4; i++) begin
            ref_op(0, 1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'h0, erd, eer);
            @(negedge clk);
            checks++;
            if ({b0.rsp_valid, b0.req_ready, b0.rsp_error} !== 3'b100 || b0.rsp_rdata !== erd) begin
                errors++;
                $display("FAIL b2b_resp i=%0d got valid=%b ready=%b err=%b rdata=%h want 1 0 0 %h",
                         i, b0.rsp_valid, b0.req_ready, b0.rsp_error, b0.rsp_rdata, erd);
            end
            b0.req_we    = 1'b1;
            b0.req_wdata = $urandom;
            b0.req_wmask = 4'hF;
            @(negedge clk);
            checks++;
            if ({b0.rsp_valid, b0.req_ready} !== 2'b01 || b0.rsp_rdata !== 32'd0) begin
                errors++;
                $display("FAIL b2b_idle i=%0d got valid=%b ready=%b rdata=%h want 0 1 0",
                         i, b0.rsp_valid, b0.req_ready, b0.rsp_rdata);
            end
            b0.req_we   = 1'b0;
            b0.req_addr = 32'h40 + 32'(4 * (i + 1));
            if (i == 3) b0.req_valid = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            ref_op(0, 1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'h0, erd, eer);
            xact(1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'h0, rd, er, n);
            checks++;
            if (rd !== erd || n != 1) begin
                errors++;
                $display("FAIL b2b_readback i=%0d got rdata=%h n=%0d want %h 1", i, rd, n, erd);
            end
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd, erd;
        logic er, eer;
        int n;
        bit seen = 0;
        use_dut(3);
        ref_op(3, 1'b1, 32'h80, 32'h11223344, 4'hF, erd, eer);
        xact(1'b1, 32'h80, 32'h11223344, 4'hF, rd, er, n);
        checks++;
        if (n != 4 || er !== 1'b0) begin
            errors++;
            $display("FAIL lat3_store got n=%0d err=%b want 4 0", n, er);
        end
        @(negedge clk);
        b3.req_valid = 1'b1;
        b3.req_we    = 1'b1;
        b3.req_addr  = 32'h80;
        b3.req_wdata = 32'hCAFEF00D;
        b3.req_wmask = 4'hF;
        @(posedge clk);
        #1;
        b3.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (b3.rsp_valid) seen = 1;
        end
        checks++;
        if (seen || b3.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_rsp got seen=%0d ready=%b want 0 1", seen, b3.req_ready);
        end
        ref_op(3, 1'b0, 32'h80, 32'h0, 4'h0, erd, eer);
        xact(1'b0, 32'h80, 32'h0, 4'h0, rd, er, n);
        checks++;
        if (rd !== erd || er !== 1'b0 || n != 4) begin
            errors++;
            $display("FAIL abort_readback got rdata=%h err=%b n=%0d want %h 0 4", rd, er, n, erd);
        end
    endtask

    initial begin
        b0.req_valid = 1'b0;
        b1.req_valid = 1'b0;
        b3.req_valid = 1'b0;
        {b0.req_we, b0.req_addr, b0.req_wdata, b0.req_wmask} = '0;
        {b1.req_we, b1.req_addr, b1.req_wdata, b1.req_wmask} = '0;
        {b3.req_we, b3.req_addr, b3.req_wdata, b3.req_wmask} = '0;
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_out_of_range();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
